alu_rs: RTL and testbench

//  Reservation station and issue scheduler for the integer ALU (R/I-type ALU ops and branches).

---
 rtl/alu_rs.sv | 207 ++++++++++++++++++++
 tb/tb_alu_rs.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// Integer-ALU reservation station: buffers dispatched ops, snoops the ALU/LSB result buses, issues one ready op per cycle.
// Optional feature macro ALU_RS_BYPASS_EN: select also accepts operands broadcast this cycle, muxing the value from the CDB.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             in_valid,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_precise,
  input  logic             in_more_precise,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [ROB_W-1:0] in_rob_entry,
  input  logic             in_qj_busy,
  input  logic             in_qk_busy,
  input  logic [31:0]      in_vj,
  input  logic [31:0]      in_vk,
  input  logic [ROB_W-1:0] in_qj,
  input  logic [ROB_W-1:0] in_qk,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob,
  input  logic [31:0]      lsb_cdb_val,
  output logic             out_full,
  output logic             out_config,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_imm,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_precise,
  output logic             out_more_precise,
  output logic [ROB_W-1:0] out_rob_entry
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       precise;
    logic             more_precise;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [ROB_W-1:0] rob;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic             rdy_j;
    logic             rdy_k;
  } entry_t;

  entry_t             ent_q [RS_SIZE];
  entry_t             ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] busy_q;
  logic [RS_SIZE-1:0] busy_d;
  logic [RS_SIZE-1:0] ready_vec;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               alloc;
  entry_t             new_ent;
  entry_t             sel_ent;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;

  function automatic logic cdb_hit(input logic [ROB_W-1:0] tag);
    return (alu_cdb_valid && alu_cdb_rob == tag) || (lsb_cdb_valid && lsb_cdb_rob == tag);
  endfunction

  // ALU bus is checked first; ROB tags are unique so both buses never match one tag.
  function automatic logic [31:0] cdb_val(input logic [ROB_W-1:0] tag);
    return (alu_cdb_valid && alu_cdb_rob == tag) ? alu_cdb_val : lsb_cdb_val;
  endfunction

  assign out_full = &busy_q;
  assign alloc    = in_valid && !out_full && rdy && !rollback;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
`ifdef ALU_RS_BYPASS_EN
      ready_vec[i] = busy_q[i] && (ent_q[i].rdy_j || cdb_hit(ent_q[i].qj))
                               && (ent_q[i].rdy_k || cdb_hit(ent_q[i].qk));
`else
      ready_vec[i] = busy_q[i] && ent_q[i].rdy_j && ent_q[i].rdy_k;
`endif
    end
  end

  // Descending scan so the lowest index wins for both the free slot and the issue pick.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_ent = ent_q[sel_idx];
`ifdef ALU_RS_BYPASS_EN
    sel_a = sel_ent.rdy_j ? sel_ent.vj : cdb_val(sel_ent.qj);
    sel_b = sel_ent.rdy_k ? sel_ent.vk : cdb_val(sel_ent.qk);
`else
    sel_a = sel_ent.vj;
    sel_b = sel_ent.vk;
`endif
  end

  // A newly dispatched operand can be satisfied by a broadcast in the same cycle.
  always_comb begin
    new_ent.opcode       = in_opcode;
    new_ent.precise      = in_precise;
    new_ent.more_precise = in_more_precise;
    new_ent.imm          = in_imm;
    new_ent.pc           = in_pc;
    new_ent.rob          = in_rob_entry;
    new_ent.qj           = in_qj;
    new_ent.qk           = in_qk;
    new_ent.vj           = in_vj;
    new_ent.vk           = in_vk;
    new_ent.rdy_j        = !in_qj_busy;
    new_ent.rdy_k        = !in_qk_busy;
    if (in_qj_busy && cdb_hit(in_qj)) begin
      new_ent.rdy_j = 1'b1;
      new_ent.vj    = cdb_val(in_qj);
    end
    if (in_qk_busy && cdb_hit(in_qk)) begin
      new_ent.rdy_k = 1'b1;
      new_ent.vk    = cdb_val(in_qk);
    end
  end

  // NOTE: every variable gets its default at the top of the block so no latch is inferred.
  always_comb begin
    ent_d  = ent_q;
    busy_d = busy_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i] && !ent_q[i].rdy_j && cdb_hit(ent_q[i].qj)) begin
        ent_d[i].rdy_j = 1'b1;
        ent_d[i].vj    = cdb_val(ent_q[i].qj);
      end
      if (busy_q[i] && !ent_q[i].rdy_k && cdb_hit(ent_q[i].qk)) begin
        ent_d[i].rdy_k = 1'b1;
        ent_d[i].vk    = cdb_val(ent_q[i].qk);
      end
    end
    if (sel_found) busy_d[sel_idx] = 1'b0;
    // free_idx comes from registered busy, so a slot freed by this issue is never reused this cycle.
    if (alloc) begin
      busy_d[free_idx] = 1'b1;
      ent_d[free_idx]  = new_ent;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q           <= '0;
      out_config       <= 1'b0;
      out_a            <= '0;
      out_b            <= '0;
      out_pc           <= '0;
      out_imm          <= '0;
      out_opcode       <= '0;
      out_precise      <= '0;
      out_more_precise <= 1'b0;
      out_rob_entry    <= '0;
    end else if (rollback) begin
      busy_q     <= '0;
      out_config <= 1'b0;
    end else if (rdy) begin
      busy_q     <= busy_d;
      out_config <= sel_found;
      if (sel_found) begin
        out_a            <= sel_a;
        out_b            <= sel_b;
        out_pc           <= sel_ent.pc;
        out_imm          <= sel_ent.imm;
        out_opcode       <= sel_ent.opcode;
        out_precise      <= sel_ent.precise;
        out_more_precise <= sel_ent.more_precise;
        out_rob_entry    <= sel_ent.rob;
      end
    end else begin
      out_config <= 1'b0;
    end
  end

  // NOTE: entry payload is not reset; busy_q qualifies every read, so only the valid bits need reset.
  always_ff @(posedge clk) begin
    if (rdy && !rollback) ent_q <= ent_d;
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: latency, wakeup, dispatch-time capture, full, rollback, stall, async reset.
// Expectations follow ALU_RS_BYPASS_EN when the bench is built with it.
module tb_alu_rs;

  localparam int ROB_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rdy;
  logic             rollback;
  logic             in_valid;
  logic [6:0]       in_opcode;
  logic [2:0]       in_precise;
  logic             in_more_precise;
  logic [31:0]      in_imm;
  logic [31:0]      in_pc;
  logic [ROB_W-1:0] in_rob_entry;
  logic             in_qj_busy;
  logic             in_qk_busy;
  logic [31:0]      in_vj;
  logic [31:0]      in_vk;
  logic [ROB_W-1:0] in_qj;
  logic [ROB_W-1:0] in_qk;
  logic             alu_cdb_valid;
  logic [ROB_W-1:0] alu_cdb_rob;
  logic [31:0]      alu_cdb_val;
  logic             lsb_cdb_valid;
  logic [ROB_W-1:0] lsb_cdb_rob;
  logic [31:0]      lsb_cdb_val;
  logic             out_full;
  logic             out_config;
  logic [31:0]      out_a;
  logic [31:0]      out_b;
  logic [31:0]      out_pc;
  logic [31:0]      out_imm;
  logic [6:0]       out_opcode;
  logic [2:0]       out_precise;
  logic             out_more_precise;
  logic [ROB_W-1:0] out_rob_entry;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  alu_rs #(.RS_SIZE(8), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .in_valid(in_valid), .in_opcode(in_opcode), .in_precise(in_precise),
    .in_more_precise(in_more_precise), .in_imm(in_imm), .in_pc(in_pc),
    .in_rob_entry(in_rob_entry), .in_qj_busy(in_qj_busy), .in_qk_busy(in_qk_busy),
    .in_vj(in_vj), .in_vk(in_vk), .in_qj(in_qj), .in_qk(in_qk),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
    .out_full(out_full), .out_config(out_config), .out_a(out_a), .out_b(out_b),
    .out_pc(out_pc), .out_imm(out_imm), .out_opcode(out_opcode),
    .out_precise(out_precise), .out_more_precise(out_more_precise),
    .out_rob_entry(out_rob_entry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [ROB_W-1:0] rob,
                          input logic qjb, input logic [ROB_W-1:0] qj, input logic [31:0] vj,
                          input logic qkb, input logic [ROB_W-1:0] qk, input logic [31:0] vk);
    in_valid        = 1'b1;
    in_opcode       = op;
    in_precise      = f3;
    in_more_precise = f7;
    in_imm          = imm;
    in_pc           = pc;
    in_rob_entry    = rob;
    in_qj_busy      = qjb;
    in_qj           = qj;
    in_vj           = vj;
    in_qk_busy      = qkb;
    in_qk           = qk;
    in_vk           = vk;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
    in_opcode = '0; in_precise = '0; in_more_precise = 1'b0; in_imm = '0; in_pc = '0;
    in_rob_entry = '0; in_qj_busy = 1'b0; in_qk_busy = 1'b0; in_vj = '0; in_vk = '0;
    in_qj = '0; in_qk = '0;
    alu_cdb_valid = 1'b0; alu_cdb_rob = '0; alu_cdb_val = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_rob = '0; lsb_cdb_val = '0;

    #3;
    check("rst_config", out_config, 0);
    check("rst_full", out_full, 0);
    check("rst_a", out_a, 0);
    #9 rst_n = 1'b1;
    step();

    // 1: ADDI with both operands ready issues at the 2nd edge after acceptance
    dispatch(OP_IMM, 3'd0, 1'b0, 32'd7, 32'h100, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0);
    step();
    in_valid = 1'b0;
    check("t1_cfg_edge1", out_config, 0);
    step();
    check("t1_cfg", out_config, 1);
    check("t1_a", out_a, 5);
    check("t1_imm", out_imm, 7);
    check("t1_rob", out_rob_entry, 3);
    check("t1_pc", out_pc, 32'h100);
    check("t1_op", out_opcode, OP_IMM);
    step();
    check("t1_cfg_drop", out_config, 0);
    check("t1_a_hold", out_a, 5);

    // 2: SUB waiting on tag 2, ALU CDB one cycle later
    dispatch(OP_REG, 3'd0, 1'b1, 32'd0, 32'h104, 4'd4, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd4);
    step();
    in_valid = 1'b0;
    alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd2; alu_cdb_val = 32'd10;
    step();
    alu_cdb_valid = 1'b0;
`ifdef ALU_RS_BYPASS_EN
    check("t2_cfg", out_config, 1);
    check("t2_a", out_a, 10);
    check("t2_b", out_b, 4);
    check("t2_f7", out_more_precise, 1);
    check("t2_rob", out_rob_entry, 4);
    step();
    check("t2_cfg_drop", out_config, 0);
`else
    check("t2_cfg_wake", out_config, 0);
    step();
    check("t2_cfg", out_config, 1);
    check("t2_a", out_a, 10);
    check("t2_b", out_b, 4);
    check("t2_f7", out_more_precise, 1);
    check("t2_rob", out_rob_entry, 4);
    step();
    check("t2_cfg_drop", out_config, 0);
`endif

    // 3: LSB broadcast in the dispatch cycle is captured by the new entry
    dispatch(OP_REG, 3'd4, 1'b0, 32'd0, 32'h108, 4'd5, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd1);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd6; lsb_cdb_val = 32'hDEAD;
    step();
    in_valid = 1'b0; lsb_cdb_valid = 1'b0;
    check("t3_cfg_edge1", out_config, 0);
    step();
    check("t3_cfg", out_config, 1);
    check("t3_a", out_a, 32'hDEAD);
    check("t3_b", out_b, 1);
    check("t3_f3", out_precise, 4);
    step();

    // 4: fill all 8 entries waiting on tag 1, 9th ignored, then in-order drain
    for (int k = 0; k < 8; k++) begin
      dispatch(OP_REG, 3'd0, 1'b0, 32'd0, 32'h200 + 32'(4 * k), 4'(8 + k),
               1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'(k));
      step();
    end
    dispatch(OP_REG, 3'd0, 1'b0, 32'd0, 32'h2F0, 4'd7, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd99);
    check("t4_full", out_full, 1);
    step();
    check("t4_full_hold", out_full, 1);
    check("t4_cfg_idle", out_config, 0);
    in_valid = 1'b0;
    alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd1; alu_cdb_val = 32'h100;
    step();
    alu_cdb_valid = 1'b0;
`ifndef ALU_RS_BYPASS_EN
    check("t4_cfg_wake", out_config, 0);
    check("t4_full_wake", out_full, 1);
    step();
`endif
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_cfg_%0d", k), out_config, 1);
      check($sformatf("t4_b_%0d", k), out_b, 32'(k));
      check($sformatf("t4_rob_%0d", k), out_rob_entry, 32'(8 + k));
      check($sformatf("t4_a_%0d", k), out_a, 32'h100);
      if (k == 0) check("t4_full_drop", out_full, 0);
      step();
    end
    check("t4_no_9th", out_config, 0);
    check("t4_empty", out_full, 0);

    // 5: rollback flushes waiting and ready entries and drops a same-cycle alloc
    dispatch(OP_REG, 3'd0, 1'b0, 32'd0, 32'h500, 4'd1, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'h11);
    step();
    dispatch(OP_REG, 3'd0, 1'b0, 32'd0, 32'h504, 4'd2, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'h22);
    step();
    dispatch(OP_IMM, 3'd0, 1'b0, 32'd1, 32'h508, 4'd3, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'd0);
    step();
    dispatch(OP_IMM, 3'd0, 1'b0, 32'd1, 32'h50C, 4'd4, 1'b0, 4'd0, 32'h55, 1'b0, 4'd0, 32'd0);
    rollback = 1'b1;
    step();
    rollback = 1'b0; in_valid = 1'b0;
    check("t5_cfg", out_config, 0);
    check("t5_full", out_full, 0);
    check("t5_a_hold", out_a, 32'h100);
    step();
    check("t5_cfg_after", out_config, 0);
    alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd5; alu_cdb_val = 32'h99;
    step();
    alu_cdb_valid = 1'b0;
    check("t5_cfg_cdb", out_config, 0);
    step();
    check("t5_cfg_gone", out_config, 0);
    check("t5_a_gone", out_a, 32'h100);

    // 6: rdy=0 stalls a ready entry, which issues unchanged once rdy returns
    dispatch(OP_BR, 3'd1, 1'b0, 32'h10, 32'h300, 4'd6, 1'b0, 4'd0, 32'h1234, 1'b0, 4'd0, 32'h5678);
    step();
    in_valid = 1'b0; rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t6_stall_%0d", k), out_config, 0);
    end
    rdy = 1'b1;
    step();
    check("t6_cfg", out_config, 1);
    check("t6_a", out_a, 32'h1234);
    check("t6_b", out_b, 32'h5678);
    check("t6_pc", out_pc, 32'h300);
    check("t6_f3", out_precise, 1);
    check("t6_op", out_opcode, OP_BR);
    step();

    // 7: asynchronous reset while an issue is on the outputs
    dispatch(OP_IMM, 3'd2, 1'b0, 32'h42, 32'h400, 4'd9, 1'b0, 4'd0, 32'hABCD, 1'b0, 4'd0, 32'd0);
    step();
    in_valid = 1'b0;
    step();
    check("t7_cfg_pre", out_config, 1);
    check("t7_a_pre", out_a, 32'hABCD);
    #2 rst_n = 1'b0;
    #1;
    check("t7_cfg", out_config, 0);
    check("t7_a", out_a, 0);
    check("t7_imm", out_imm, 0);
    check("t7_pc", out_pc, 0);
    check("t7_rob", out_rob_entry, 0);
    check("t7_f3", out_precise, 0);
    check("t7_full", out_full, 0);
    #5 rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
